// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-master APB3 arbiter/decoder.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int          NUM_SLV   = 4;
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  function automatic logic [NUM_SLV-1:0] idx_to_sel(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/apb_addr_dec.sv
// Address decoder: everything above the 2-bit slave field must be zero to be mapped.
module apb_addr_dec
  import apb_arb_pkg::*;
#(
  parameter int SEL_LSB = 12
) (
  input  logic [31-SEL_LSB:0] addr_hi,
  output logic                mapped,
  output logic [1:0]          idx
);

  assign idx    = addr_hi[1:0];
  assign mapped = (addr_hi[31-SEL_LSB:2] == '0);

endmodule

// File: rtl/apb_arb_dec.sv
// Round-robin arbiter for two requesters onto one APB3 bus, with slave decode,
// SETUP/ACCESS sequencing, timeout and error termination.
module apb_arb_dec
  import apb_arb_pkg::*;
#(
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         m0_req,
  input  logic         m1_req,
  input  logic [31:0]  m0_addr,
  input  logic [31:0]  m1_addr,
  input  logic         m0_write,
  input  logic         m1_write,
  input  logic [31:0]  m0_wdata,
  input  logic [31:0]  m1_wdata,
  output logic         m0_done,
  output logic         m1_done,
  output logic [31:0]  m0_rdata,
  output logic [31:0]  m1_rdata,
  output logic         m0_err,
  output logic         m1_err,
  output logic [3:0]   psel,
  output logic         penable,
  output logic [31:0]  paddr,
  output logic         pwrite,
  output logic [31:0]  pwdata,
  input  logic [127:0] prdata,
  input  logic [3:0]   pready,
  input  logic [3:0]   pslverr
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_r;
  logic             grant_r;
  logic             last_grant_r;
  logic [1:0]       idx_r;
  logic [CNT_W-1:0] cnt_r;

  logic             win1_s;
  logic [31:0]      req_addr_s;
  logic             req_write_s;
  logic [31:0]      req_wdata_s;
  logic             dec_mapped_s;
  logic [1:0]       dec_idx_s;
  logic             fin_s;
  logic             fin_m1_s;
  logic             fin_read_s;
  logic             fin_err_s;
  logic [31:0]      fin_rdata_s;

  // Round-robin pick: on a tie the requester that was not granted last wins.
  always_comb begin
    win1_s      = 1'b0;
    req_addr_s  = m0_addr;
    req_write_s = m0_write;
    req_wdata_s = m0_wdata;
    if (m1_req && (!m0_req || !last_grant_r)) begin
      win1_s      = 1'b1;
      req_addr_s  = m1_addr;
      req_write_s = m1_write;
      req_wdata_s = m1_wdata;
    end else begin
      win1_s      = 1'b0;
    end
  end

  apb_addr_dec #(.SEL_LSB(SEL_LSB)) u_dec (
    .addr_hi (req_addr_s[31:SEL_LSB]),
    .mapped  (dec_mapped_s),
    .idx     (dec_idx_s)
  );

  // Completion qualifier: unmapped in IDLE, or slave ready / timeout in ACCESS.
  always_comb begin
    fin_s       = 1'b0;
    fin_m1_s    = grant_r;
    fin_read_s  = !pwrite;
    fin_err_s   = 1'b0;
    fin_rdata_s = ERR_RDATA;
    case (state_r)
      IDLE: begin
        if ((m0_req || m1_req) && !dec_mapped_s) begin
          fin_s      = 1'b1;
          fin_m1_s   = win1_s;
          fin_read_s = !req_write_s;
          fin_err_s  = 1'b1;
        end else begin
          fin_s      = 1'b0;
        end
      end
      ACCESS: begin
        if (pready[idx_r]) begin
          fin_s       = 1'b1;
          fin_err_s   = pslverr[idx_r];
          fin_rdata_s = prdata[{idx_r, 5'd0} +: 32];
        end else if ((TIMEOUT != 0) && (cnt_r == TO_LAST)) begin
          fin_s       = 1'b1;
          fin_err_s   = 1'b1;
        end else begin
          fin_s       = 1'b0;
        end
      end
      default: fin_s = 1'b0;
    endcase
  end

  // Main FSM with registered bus and requester outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      idx_r        <= 2'd0;
      cnt_r        <= '0;
      psel         <= 4'b0000;
      penable      <= 1'b0;
      paddr        <= 32'h0000_0000;
      pwrite       <= 1'b0;
      pwdata       <= 32'h0000_0000;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      m0_rdata     <= 32'h0000_0000;
      m1_rdata     <= 32'h0000_0000;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
      if (fin_s) begin
        if (fin_m1_s) begin
          m1_done <= 1'b1;
          m1_err  <= fin_err_s;
          if (fin_read_s) m1_rdata <= fin_rdata_s;
        end else begin
          m0_done <= 1'b1;
          m0_err  <= fin_err_s;
          if (fin_read_s) m0_rdata <= fin_rdata_s;
        end
      end
      case (state_r)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant_r      <= win1_s;
            last_grant_r <= win1_s;
            paddr        <= req_addr_s;
            pwrite       <= req_write_s;
            pwdata       <= req_wdata_s;
            idx_r        <= dec_idx_s;
            if (dec_mapped_s) begin
              state_r <= SETUP;
              psel    <= idx_to_sel(dec_idx_s);
            end else begin
              state_r <= DONE;
            end
          end
        end
        SETUP: begin
          penable <= 1'b1;
          cnt_r   <= '0;
          state_r <= ACCESS;
        end
        ACCESS: begin
          cnt_r <= cnt_r + CNT_W'(1'b1);
          if (fin_s) begin
            state_r <= DONE;
            psel    <= 4'b0000;
            penable <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          psel    <= 4'b0000;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_dec.sv
// Directed self-checking bench for apb_arb_dec (TIMEOUT reduced to 4).
module tb_apb_arb_dec;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         m0_req, m1_req, m0_write, m1_write;
  logic [31:0]  m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic         m0_done, m1_done, m0_err, m1_err;
  logic [31:0]  m0_rdata, m1_rdata;
  logic [3:0]   psel;
  logic         penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [127:0] prdata;
  logic [3:0]   pready, pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_arb_dec #(.SEL_LSB(12), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_write(m0_write), .m1_write(m1_write), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_done(m0_done), .m1_done(m1_done), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_err(m0_err), .m1_err(m1_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    n_cmp++; if ({psel, penable, pwrite, m0_done, m1_done, m0_err, m1_err} !== 10'd0) begin n_bad++; $display("FAIL reset_ctrl: got %b exp 0", {psel, penable, pwrite, m0_done, m1_done, m0_err, m1_err}); end
    n_cmp++; if (paddr !== 32'h0) begin n_bad++; $display("FAIL reset_paddr: got %h exp 0", paddr); end
    n_cmp++; if (pwdata !== 32'h0) begin n_bad++; $display("FAIL reset_pwdata: got %h exp 0", pwdata); end
    n_cmp++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h exp 0", {m0_rdata, m1_rdata}); end
    reset_n = 1'b1;
    step();
    n_cmp++; if (psel !== 4'b0000) begin n_bad++; $display("FAIL idle_psel: got %b exp 0000", psel); end
  endtask

  task automatic test_arbitration();
    logic [3:0]  exp_sel;
    logic [31:0] exp_wd;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    pready = 4'b1111; pslverr = 4'b0000;
    m0_addr = 32'h0000_0000; m0_write = 1'b1; m0_wdata = 32'h1111_0000;
    m1_addr = 32'h0000_2000; m1_write = 1'b1; m1_wdata = 32'h2222_0000;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_sel = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      exp_wd  = (i % 2 == 0) ? 32'h1111_0000 : 32'h2222_0000;
      step();
      n_cmp++; if (psel !== exp_sel) begin n_bad++; $display("FAIL arb_psel[%0d]: got %b exp %b", i, psel, exp_sel); end
      n_cmp++; if ({pwrite, pwdata} !== {1'b1, exp_wd}) begin n_bad++; $display("FAIL arb_pwdata[%0d]: got %h exp %h", i, pwdata, exp_wd); end
      step();
      step();
      n_cmp++; if ({m0_done, m1_done} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL arb_done[%0d]: got %b%b exp %s", i, m0_done, m1_done, (i % 2 == 0) ? "10" : "01"); end
      if (i == 3) begin m0_req = 1'b0; m1_req = 1'b0; end
      step();
    end
  endtask

  task automatic test_single_read();
    pready = 4'b0010; pslverr = 4'b0000;
    prdata = 128'h0; prdata[63:32] = 32'hCAFE_0001;
    m0_addr = 32'h0000_1004; m0_write = 1'b0; m0_req = 1'b1;
    step();
    n_cmp++; if ({psel, penable} !== 5'b0010_0) begin n_bad++; $display("FAIL rd_setup: got %b exp 00100", {psel, penable}); end
    n_cmp++; if ({paddr, pwrite} !== {32'h0000_1004, 1'b0}) begin n_bad++; $display("FAIL rd_paddr: got %h/%b exp 00001004/0", paddr, pwrite); end
    step();
    n_cmp++; if ({psel, penable, m0_done} !== 6'b0010_1_0) begin n_bad++; $display("FAIL rd_access: got %b exp 001010", {psel, penable, m0_done}); end
    step();
    n_cmp++; if ({m0_done, m0_err, m1_done, psel, penable} !== 8'b1_0_0_0000_0) begin n_bad++; $display("FAIL rd_done: got %b exp 10000000", {m0_done, m0_err, m1_done, psel, penable}); end
    n_cmp++; if (m0_rdata !== 32'hCAFE_0001) begin n_bad++; $display("FAIL rd_rdata: got %h exp cafe0001", m0_rdata); end
    m0_req = 1'b0;
    step();
    n_cmp++; if ({m0_done, m0_rdata} !== {1'b0, 32'hCAFE_0001}) begin n_bad++; $display("FAIL rd_hold: got %b/%h exp 0/cafe0001", m0_done, m0_rdata); end
  endtask

  task automatic test_wait_states();
    pready = 4'b0000; pslverr = 4'b0100;
    prdata = 128'h0; prdata[95:64] = 32'h5A5A_0002;
    m1_addr = 32'h0000_2008; m1_write = 1'b0; m1_req = 1'b1;
    step();
    n_cmp++; if (psel !== 4'b0100) begin n_bad++; $display("FAIL ws_setup_psel: got %b exp 0100", psel); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) pready = 4'b0100;
      n_cmp++; if ({psel, penable, m1_done} !== 6'b0100_1_0) begin n_bad++; $display("FAIL ws_access[%0d]: got %b exp 010010", i, {psel, penable, m1_done}); end
    end
    step();
    n_cmp++; if ({m1_done, m1_err, psel} !== 6'b1_1_0000) begin n_bad++; $display("FAIL ws_done: got %b exp 110000", {m1_done, m1_err, psel}); end
    n_cmp++; if (m1_rdata !== 32'h5A5A_0002) begin n_bad++; $display("FAIL ws_rdata: got %h exp 5a5a0002", m1_rdata); end
    m1_req = 1'b0; pready = 4'b0000; pslverr = 4'b0000;
    step();
  endtask

  task automatic test_unmapped();
    m1_addr = 32'h0001_0000; m1_write = 1'b0; m1_req = 1'b1;
    pready = 4'b1111;
    step();
    n_cmp++; if ({m1_done, m1_err, m0_done, psel, penable} !== 8'b1_1_0_0000_0) begin n_bad++; $display("FAIL um_done: got %b exp 11000000", {m1_done, m1_err, m0_done, psel, penable}); end
    n_cmp++; if (m1_rdata !== 32'h0) begin n_bad++; $display("FAIL um_rdata: got %h exp 0", m1_rdata); end
    m1_req = 1'b0;
    step();
    n_cmp++; if ({m1_done, m1_err, psel} !== 6'b0) begin n_bad++; $display("FAIL um_after: got %b exp 000000", {m1_done, m1_err, psel}); end
  endtask

  task automatic test_timeout();
    pready = 4'b0000; pslverr = 4'b0000; prdata = 128'h0;
    m0_addr = 32'h0000_3000; m0_write = 1'b0; m0_req = 1'b1;
    step();
    n_cmp++; if ({psel, penable} !== 5'b1000_0) begin n_bad++; $display("FAIL to_setup: got %b exp 10000", {psel, penable}); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({psel, penable, m0_done} !== 6'b1000_1_0) begin n_bad++; $display("FAIL to_access[%0d]: got %b exp 100010", i, {psel, penable, m0_done}); end
    end
    step();
    n_cmp++; if ({m0_done, m0_err, psel, penable} !== 7'b1_1_0000_0) begin n_bad++; $display("FAIL to_done: got %b exp 1100000", {m0_done, m0_err, psel, penable}); end
    n_cmp++; if (m0_rdata !== 32'h0) begin n_bad++; $display("FAIL to_rdata: got %h exp 0", m0_rdata); end
    step();
    pready = 4'b1000; pslverr = 4'b1000; prdata[127:96] = 32'h3333_0003;
    step();
    step();
    step();
    n_cmp++; if ({m0_done, m0_err} !== 2'b11) begin n_bad++; $display("FAIL slverr_done: got %b exp 11", {m0_done, m0_err}); end
    n_cmp++; if (m0_rdata !== 32'h3333_0003) begin n_bad++; $display("FAIL slverr_rdata: got %h exp 33330003", m0_rdata); end
    m0_req = 1'b0; pready = 4'b0000; pslverr = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid();
    m0_addr = 32'h0000_1000; m0_write = 1'b0; m0_req = 1'b1;
    m1_addr = 32'h0000_2000; m1_write = 1'b0;
    step();
    step();
    n_cmp++; if ({psel, penable} !== 5'b0010_1) begin n_bad++; $display("FAIL rm_access: got %b exp 00101", {psel, penable}); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({psel, penable, m0_done, m1_done} !== 7'b0) begin n_bad++; $display("FAIL rm_abort: got %b exp 0000000", {psel, penable, m0_done, m1_done}); end
    m1_req = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    n_cmp++; if ({psel, m0_done} !== 5'b0010_0) begin n_bad++; $display("FAIL rm_tie_m0: got %b exp 00100", {psel, m0_done}); end
    reset_n = 1'b0;
    m0_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    n_cmp++; if (psel !== 4'b0100) begin n_bad++; $display("FAIL rm_m1_only: got %b exp 0100", psel); end
    pready = 4'b0100; prdata = 128'h0; prdata[95:64] = 32'h7777_0002;
    step();
    step();
    n_cmp++; if ({m1_done, m1_err, m0_done, m1_rdata} !== {3'b100, 32'h7777_0002}) begin n_bad++; $display("FAIL rm_m1_done: got %b/%h exp 100/77770002", {m1_done, m1_err, m0_done}, m1_rdata); end
    m1_req = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    prdata = 128'h0; pready = 4'b0000; pslverr = 4'b0000;
    test_reset();
    test_arbitration();
    test_single_read();
    test_wait_states();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
